// File: rtl/gol_generation_sequencer_if.sv
// gol_generation_sequencer_if: control inputs and datapath/status outputs of the generation sequencer.
// The master side drives the controls; the slave side is the sequencer.
interface gol_generation_sequencer_if #(
   parameter int GRID_SIZE = 8,
   parameter int GEN_W = 16
);
   localparam int IDXW = $clog2(GRID_SIZE * GRID_SIZE);
   localparam int CW = $clog2(GRID_SIZE);
   logic pause, step, moveleft, moveright, moveup, movedown;
   logic [IDXW-1:0] cell_idx;
   logic cell_en, commit, updatesignal, controlsignal, paused, busy;
   logic [CW-1:0] cursor_x, cursor_y;
   logic [GEN_W-1:0] generation;
   modport master (
      output pause, step, moveleft, moveright, moveup, movedown,
      input cell_idx, cell_en, commit, updatesignal, controlsignal, cursor_x, cursor_y, paused, busy, generation
   );
   modport slave (
      input pause, step, moveleft, moveright, moveup, movedown,
      output cell_idx, cell_en, commit, updatesignal, controlsignal, cursor_x, cursor_y, paused, busy, generation
   );
endinterface

// File: rtl/gol_generation_sequencer.sv
// gol_generation_sequencer: per-generation cell sweep, commit and update pulse; owns pause/step and edit cursor.
// Define GOL_SEQ_MOVE_HOLD_EN to hold cursor moves requested while busy until the sequencer returns to IDLE.
module gol_generation_sequencer #(
   parameter int GRID_SIZE = 8,
   parameter int GEN_PERIOD = 4,
   parameter int GEN_W = 16
) (
   input logic clk,
   input logic reset,
   gol_generation_sequencer_if.slave bus_if
);
   localparam int IDXW = $clog2(GRID_SIZE * GRID_SIZE);
   localparam int CW = $clog2(GRID_SIZE);
   localparam int PW = $clog2(GEN_PERIOD + 1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(GRID_SIZE * GRID_SIZE - 1);
   localparam logic [CW-1:0] MAX_C = CW'(GRID_SIZE - 1);
   localparam logic [PW-1:0] LAST_CNT = PW'(GEN_PERIOD - 1);
   typedef enum logic [1:0] {IDLE, SWEEP, COMMIT, NOTIFY} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [GEN_W-1:0] gen_q, gen_d;
   logic [CW-1:0] x_q, x_d, y_q, y_d;
   logic [5:0] lvl, lvl_q, rise;
   logic [3:0] pend_q, pend_d, move_e, req, grant;
   logic pause_e, step_e, paused_q, ctrl_q, ctrl_d, cell_en_q, commit_q, upd_q, busy_q;
   // level inputs packed as {pause, step, left, right, up, down}
   assign lvl = {bus_if.pause, bus_if.step, bus_if.moveleft, bus_if.moveright, bus_if.moveup, bus_if.movedown};
   assign rise = lvl & ~lvl_q;
   assign pause_e = rise[5];
   assign step_e = rise[4];
   assign move_e = rise[3:0];
   assign req = pend_q | move_e;
   assign grant = req[3] ? 4'b1000 : req[2] ? 4'b0100 : req[1] ? 4'b0010 : req[0] ? 4'b0001 : 4'b0000;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      idx_d = '0;
      gen_d = gen_q;
      x_d = x_q;
      y_d = y_q;
      ctrl_d = 1'b0;
`ifdef GOL_SEQ_MOVE_HOLD_EN
      pend_d = pend_q | move_e;
`else
      pend_d = pend_q;
`endif
      case (state_q)
         IDLE: begin
            // simultaneous move edges are queued so each direction is applied on its own cycle
            if (|req) begin
               ctrl_d = 1'b1;
               pend_d = req & ~grant;
               x_d = grant[3] ? (x_q == '0 ? MAX_C : x_q - 1'b1) : grant[2] ? (x_q == MAX_C ? '0 : x_q + 1'b1) : x_q;
               y_d = grant[1] ? (y_q == '0 ? MAX_C : y_q - 1'b1) : grant[0] ? (y_q == MAX_C ? '0 : y_q + 1'b1) : y_q;
            end else if (!paused_q && !pause_e) begin
               cnt_d = cnt_q == LAST_CNT ? '0 : cnt_q + 1'b1;
               state_d = cnt_q == LAST_CNT ? SWEEP : IDLE;
            end else if (paused_q && step_e && !pause_e) begin
               cnt_d = '0;
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            idx_d = idx_q == LAST_IDX ? '0 : idx_q + 1'b1;
            state_d = idx_q == LAST_IDX ? COMMIT : SWEEP;
         end
         COMMIT: begin
            gen_d = gen_q + 1'b1;
            state_d = NOTIFY;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         idx_q <= '0;
         gen_q <= '0;
         x_q <= '0;
         y_q <= '0;
         lvl_q <= '0;
         pend_q <= '0;
         paused_q <= 1'b0;
         ctrl_q <= 1'b0;
         cell_en_q <= 1'b0;
         commit_q <= 1'b0;
         upd_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         gen_q <= gen_d;
         x_q <= x_d;
         y_q <= y_d;
         lvl_q <= lvl;
         pend_q <= pend_d;
         paused_q <= paused_q ^ pause_e;
         ctrl_q <= ctrl_d;
         cell_en_q <= state_d == SWEEP;
         commit_q <= state_d == COMMIT;
         upd_q <= state_d == NOTIFY;
         busy_q <= state_d != IDLE;
      end
   end
   assign bus_if.cell_idx = idx_q;
   assign bus_if.cell_en = cell_en_q;
   assign bus_if.commit = commit_q;
   assign bus_if.updatesignal = upd_q;
   assign bus_if.controlsignal = ctrl_q;
   assign bus_if.cursor_x = x_q;
   assign bus_if.cursor_y = y_q;
   assign bus_if.paused = paused_q;
   assign bus_if.busy = busy_q;
   assign bus_if.generation = gen_q;
endmodule

// File: tb/tb_gol_generation_sequencer.sv
// tb_gol_generation_sequencer: directed and random stimulus; a countdown reference model predicts every
// output event (cell/commit/update/control) into a queue that an independent monitor pops and compares.
`timescale 1ns/1ps
module tb_gol_generation_sequencer;
   localparam int N = 4, P = 2, GW = 16;
   logic clk = 1'b0, reset = 1'b1;
   int cyc = 0, checks = 0, errors = 0;
   int n_cell = 0, n_com = 0, n_upd = 0, n_ctrl = 0, last_upd_cyc = -1;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   gol_generation_sequencer_if #(.GRID_SIZE(N), .GEN_W(GW)) bus_if();
   gol_generation_sequencer #(.GRID_SIZE(N), .GEN_PERIOD(P), .GEN_W(GW)) dut (.clk(clk), .reset(reset), .bus_if(bus_if));
   typedef struct {int cyc; logic [27:0] snap;} ev_t;
   ev_t q[$];
   logic [5:0] m_prev;
   logic [3:0] m_pend;
   logic [GW-1:0] m_gen;
   bit m_paused;
   int m_busy_left, m_cnt, m_x, m_y;
   // snapshot = {kind, idx, generation, x, y, paused, busy}; kind 0 cell, 1 commit, 2 update, 3 control
   function automatic void push(input int c, input int kind, input int idx, input bit busy);
      ev_t ev;
      ev.cyc = c;
      ev.snap = {2'(kind), 4'(idx), m_gen, 2'(m_x), 2'(m_y), m_paused, busy};
      q.push_back(ev);
   endfunction
   task automatic model_step(input logic r, input logic [5:0] in, input int k);
      logic [5:0] e;
      logic [3:0] req;
      bit start, moved;
      int p;
      if (r) begin
         m_prev = '0; m_pend = '0; m_gen = '0; m_paused = 0;
         m_busy_left = 0; m_cnt = 0; m_x = 0; m_y = 0;
         return;
      end
      e = in & ~m_prev;
      m_prev = in;
      start = 0;
      moved = 0;
      if (m_busy_left > 0) begin
`ifdef GOL_SEQ_MOVE_HOLD_EN
         m_pend |= e[3:0];
`endif
         if (N * N + 2 - m_busy_left == N * N) m_gen++;
         m_busy_left--;
      end else begin
         req = m_pend | e[3:0];
         if (req != 0) begin
            moved = 1;
            if (req[3]) begin m_x = (m_x + N - 1) % N; req[3] = 0; end
            else if (req[2]) begin m_x = (m_x + 1) % N; req[2] = 0; end
            else if (req[1]) begin m_y = (m_y + N - 1) % N; req[1] = 0; end
            else begin m_y = (m_y + 1) % N; req[0] = 0; end
            m_pend = req;
         end else if (!m_paused && !e[5]) begin
            m_cnt++;
            if (m_cnt == P) begin m_cnt = 0; start = 1; end
         end else if (m_paused && e[4] && !e[5]) begin
            m_cnt = 0;
            start = 1;
         end
      end
      m_paused ^= e[5];
      if (start) m_busy_left = N * N + 2;
      if (moved) push(k + 1, 3, 0, 0);
      if (m_busy_left > 0) begin
         p = N * N + 2 - m_busy_left;
         push(k + 1, p < N * N ? 0 : p == N * N ? 1 : 2, p < N * N ? p : 0, 1);
      end
   endtask
   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic drive(input logic r, input logic [5:0] in);
      reset = r;
      {bus_if.pause, bus_if.step, bus_if.moveleft, bus_if.moveright, bus_if.moveup, bus_if.movedown} = in;
      model_step(r, in, cyc);
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 6'b0);
   endtask
   task automatic pulse(input logic [5:0] in);
      drive(1'b0, in);
      drive(1'b0, 6'b0);
   endtask
   always @(negedge clk) begin
      logic [3:0] pl;
      logic [1:0] kind;
      logic [27:0] act;
      ev_t ev;
      pl = {bus_if.cell_en, bus_if.commit, bus_if.updatesignal, bus_if.controlsignal};
      n_cell += int'(bus_if.cell_en);
      n_com += int'(bus_if.commit);
      n_upd += int'(bus_if.updatesignal);
      n_ctrl += int'(bus_if.controlsignal);
      if (bus_if.updatesignal) last_upd_cyc = cyc;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         ev = q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: cycle %0d got no output event, expected snapshot %h", ev.cyc, ev.snap);
      end
      if (pl != 0) begin
         kind = bus_if.controlsignal ? 2'd3 : bus_if.updatesignal ? 2'd2 : bus_if.commit ? 2'd1 : 2'd0;
         act = {kind, bus_if.cell_en ? bus_if.cell_idx : 4'd0, bus_if.generation, bus_if.cursor_x,
                bus_if.cursor_y, bus_if.paused, bus_if.busy};
         checks++;
         if (q.size() == 0 || q[0].cyc != cyc) begin
            errors++;
            $display("FAIL unexpected_event: cycle %0d got pulses %b snapshot %h, none expected", cyc, pl, act);
         end else begin
            ev = q.pop_front();
            if (act !== ev.snap || $countones(pl) != 1) begin
               errors++;
               $display("FAIL event_snapshot: cycle %0d got pulses %b snapshot %h expected %h", cyc, pl, act, ev.snap);
            end
         end
      end
   end
   initial begin
      int c_cell, c_com, c_upd, c_ctrl, t0;
      drive(1'b1, 6'b0);
      drive(1'b1, 6'b0);
      check("reset_outputs", {bus_if.cell_en, bus_if.commit, bus_if.updatesignal, bus_if.controlsignal, bus_if.busy,
            bus_if.paused, bus_if.cell_idx, bus_if.generation, bus_if.cursor_x, bus_if.cursor_y}, 0);
      t0 = cyc;
      idle(45);
      check("first_gens_updates", n_upd, 2);
      check("second_update_cycle", last_upd_cyc - t0, 39);
      check("gen_after_45", bus_if.generation, 2);
      pulse(6'b100000);
      idle(20);
      check("pause_completes_sweep_gen", bus_if.generation, 3);
      check("paused_set", bus_if.paused, 1);
      c_cell = n_cell;
      idle(100);
      check("paused_no_cells", n_cell - c_cell, 0);
      c_cell = n_cell; c_com = n_com;
      pulse(6'b010000);
      idle(25);
      check("step_cells", n_cell - c_cell, 16);
      check("step_commits", n_com - c_com, 1);
      check("step_gen", bus_if.generation, 4);
      c_ctrl = n_ctrl;
      pulse(6'b001000);
      check("left_wrap_x", bus_if.cursor_x, 3);
      check("left_ctrl_pulses", n_ctrl - c_ctrl, 1);
      pulse(6'b000010);
      check("up_wrap_y", bus_if.cursor_y, 3);
      c_ctrl = n_ctrl;
      drive(1'b0, 6'b001100);
      check("left_right_first", bus_if.cursor_x, 2);
      drive(1'b0, 6'b0);
      check("left_right_second", bus_if.cursor_x, 3);
      idle(3);
      check("left_right_ctrl", n_ctrl - c_ctrl, 2);
      c_ctrl = n_ctrl;
      pulse(6'b010000);
      idle(3);
      pulse(6'b000100);
      idle(25);
`ifdef GOL_SEQ_MOVE_HOLD_EN
      check("held_move_x", bus_if.cursor_x, 0);
      check("held_move_ctrl", n_ctrl - c_ctrl, 1);
`else
      check("dropped_move_x", bus_if.cursor_x, 3);
      check("dropped_move_ctrl", n_ctrl - c_ctrl, 0);
`endif
      pulse(6'b010000);
      idle(6);
      check("sweep_idx7", {bus_if.cell_en, bus_if.cell_idx}, {1'b1, 4'd7});
      c_com = n_com; c_upd = n_upd;
      drive(1'b1, 6'b0);
      check("midsweep_reset_outputs", {bus_if.cell_en, bus_if.cell_idx, bus_if.generation, bus_if.commit,
            bus_if.updatesignal, bus_if.busy}, 0);
      idle(6);
      check("midsweep_reset_no_pulses", (n_com - c_com) + (n_upd - c_upd), 0);
      idle(7);
      pulse(6'b010000);
      idle(50);
      check("step_unpaused_gen", bus_if.generation, m_gen);
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] in;
         for (int b = 0; b < 6; b++) in[b] = ($urandom_range(0, 7) == 0);
         if (i % 500 < 250) in[5] = 1'b0;
         drive(1'b0, in);
      end
      idle(40);
      check("final_gen", bus_if.generation, m_gen);
      check("final_cursor", {bus_if.cursor_x, bus_if.cursor_y}, {2'(m_x), 2'(m_y)});
      check("final_paused", bus_if.paused, m_paused);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
